systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_skew.sv | 69 ++++++
 rtl/systolic_ctrl.sv | 146 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM state type, default array geometry and an index-width helper
// shared by the systolic array controller and its operand skew unit.
package systolic_pkg;

  localparam int DEF_MATRIX_SIZE = 3;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACC_WIDTH   = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE
  } state_t;

  // Width needed to index 'range' items; never below one bit so degenerate sizes still elaborate.
  function automatic int width_of(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew.sv
// systolic_skew: A (left) and B (top) operand buffers plus the diagonal skew that
// presents row i / column j to the array edge delayed by i / j cycles during FEED.
module systolic_skew
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  localparam int IDX_W      = width_of(MATRIX_SIZE),
  localparam int CNT_W      = width_of(2 * MATRIX_SIZE - 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [IDX_W-1:0]                  wr_row,
  input  logic [IDX_W-1:0]                  wr_col,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              feed,
  input  logic [CNT_W-1:0]                  t,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] arr_left,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] arr_top
);

  localparam int N = MATRIX_SIZE;

  logic [DATA_WIDTH-1:0] a_buf [N][N];
  logic [DATA_WIDTH-1:0] b_buf [N][N];

  // Element-wise decode keeps out-of-range row/column codes (N not a power of two) harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (wr_row == IDX_W'(r) && wr_col == IDX_W'(c)) begin
            if (wr_sel) begin
              b_buf[r][c] <= wr_data;
            end else begin
              a_buf[r][c] <= wr_data;
            end
          end
        end
      end
    end
  end

  // Slice i carries A[i][t-i] and B[t-i][i]; the wavefront index k = t - i picks the element.
  always_comb begin
    arr_left = '0;
    arr_top  = '0;
    if (feed) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t) == i + k) begin
            arr_left[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][k];
            arr_top[i*DATA_WIDTH +: DATA_WIDTH]  = b_buf[k][i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencing FSM, cycle counter and result capture for an NxN output-stationary array.
// Optional build macro SYSTOLIC_CTRL_ACCUM_EN adds an 'accum' input that skips CLEAR to add onto prior sums.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  localparam int IDX_W      = width_of(MATRIX_SIZE)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  input  logic                                        accum,
`endif
  output logic                                        busy,
  output logic                                        done,
  input  logic                                        wr_en,
  input  logic                                        wr_sel,
  input  logic [IDX_W-1:0]                            wr_row,
  input  logic [IDX_W-1:0]                            wr_col,
  input  logic [DATA_WIDTH-1:0]                       wr_data,
  output logic                                        arr_rst,
  output logic                                        arr_en,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0]           arr_left,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0]           arr_top,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*ACC_WIDTH-1:0] arr_acc,
  output logic [MATRIX_SIZE*MATRIX_SIZE*ACC_WIDTH-1:0] result
);

  localparam int N     = MATRIX_SIZE;
  localparam int CNT_W = width_of(2 * N - 1);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             skip_clear;
  logic             feed;
  logic             wr_accept;
  logic             capture_load;

`ifdef SYSTOLIC_CTRL_ACCUM_EN
  assign skip_clear = accum;
`else
  assign skip_clear = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are gated by rst_n so a reset asserted mid-run silences the array immediately.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    arr_en     = 1'b0;
    arr_rst    = ~rst_n;
    feed       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = skip_clear ? FEED : CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        busy       = rst_n;
        arr_rst    = 1'b1;
        state_next = FEED;
        cnt_next   = '0;
      end
      FEED: begin
        busy   = rst_n;
        arr_en = rst_n;
        feed   = rst_n;
        if (cnt == FEED_LAST) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        busy   = rst_n;
        arr_en = rst_n;
        if (cnt == DRAIN_LAST) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        busy       = rst_n;
        done       = rst_n;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign wr_accept    = wr_en && rst_n && (state == IDLE);
  assign capture_load = (state == DRAIN) && (cnt == DRAIN_LAST);

  // Sums are final by the last DRAIN cycle, so loading on entry to CAPTURE makes result valid alongside done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
    end else if (capture_load) begin
      result <= arr_acc;
    end
  end

  systolic_skew #(
    .MATRIX_SIZE(MATRIX_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .feed    (feed),
    .t       (cnt),
    .arr_left(arr_left),
    .arr_top (arr_top)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench driving systolic_ctrl against a behavioural 3x3 systolic array.
// Define SYSTOLIC_CTRL_ACCUM_EN to also run the accumulate-onto-prior-sums scenario.
module tb_systolic_ctrl;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int RW = N * N * AW;

  typedef int mat_t [3][3];

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          wr_en   = 1'b0;
  logic          wr_sel  = 1'b0;
  logic [IW-1:0] wr_row  = '0;
  logic [IW-1:0] wr_col  = '0;
  logic [DW-1:0] wr_data = '0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  logic          accum   = 1'b0;
`endif
  logic          busy;
  logic          done;
  logic          arr_rst;
  logic          arr_en;
  logic [N*DW-1:0] arr_left;
  logic [N*DW-1:0] arr_top;
  logic [RW-1:0]   arr_acc;
  logic [RW-1:0]   result;

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int runs_exp = 0;

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  int            start_q[$];

  localparam mat_t M    = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
  localparam mat_t C1   = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
  localparam mat_t C1X2 = '{'{60, 72, 84}, '{132, 162, 192}, '{204, 252, 300}};
  localparam mat_t IDP  = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
  localparam mat_t A2   = '{'{2, 0, 1}, '{1, 3, 0}, '{0, 1, 4}};
  localparam mat_t C2   = '{'{9, 12, 15}, '{13, 17, 21}, '{32, 37, 42}};
  localparam mat_t FF   = '{'{255, 255, 255}, '{255, 255, 255}, '{255, 255, 255}};
  localparam mat_t CFF  = '{'{195075, 195075, 195075}, '{195075, 195075, 195075}, '{195075, 195075, 195075}};
  localparam mat_t ZZ   = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};

  systolic_ctrl #(
    .MATRIX_SIZE(N),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    .accum   (accum),
`endif
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .arr_rst (arr_rst),
    .arr_en  (arr_en),
    .arr_left(arr_left),
    .arr_top (arr_top),
    .arr_acc (arr_acc),
    .result  (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output-stationary array model: A flows right, B flows down, each PE accumulates a*b.
  logic [DW-1:0] pa   [N][N];
  logic [DW-1:0] pb   [N][N];
  logic [AW-1:0] pacc [N][N];
  logic [DW-1:0] ain  [N][N];
  logic [DW-1:0] bin  [N][N];

  always_comb begin
    arr_acc = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain[i][j] = arr_left[i*DW +: DW];
        else        ain[i][j] = pa[i][(j == 0) ? 0 : j - 1];
        if (i == 0) bin[i][j] = arr_top[j*DW +: DW];
        else        bin[i][j] = pb[(i == 0) ? 0 : i - 1][j];
        arr_acc[(i*N+j)*AW +: AW] = pacc[i][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_rst) begin
          pa[i][j]   <= '0;
          pb[i][j]   <= '0;
          pacc[i][j] <= '0;
        end else if (arr_en) begin
          pa[i][j]   <= ain[i][j];
          pb[i][j]   <= bin[i][j];
          pacc[i][j] <= pacc[i][j] + AW'(ain[i][j]) * AW'(bin[i][j]);
        end
      end
    end
  end

  function automatic logic [RW-1:0] packMat(input mat_t m);
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[(i*N+j)*AW +: AW] = AW'(m[i][j]);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Writes one operand matrix through the buffer port; returns at a negedge.
  task automatic loadMatrix(input bit sel, input mat_t m);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(i);
        wr_col  = IW'(j);
        wr_data = DW'(m[i][j]);
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
  endtask

  // Issues start from a negedge; returns at the negedge in the first busy cycle.
  task automatic applyStimulus(input bit acc, input bit expect_done, input mat_t expm);
    start = 1'b1;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accum = acc;
`endif
    @(posedge clk);
    #1;
    if (expect_done) begin
      exp_q.push_back(packMat(expm));
      lat_q.push_back(acc ? 3 * N : 3 * N + 1);
      start_q.push_back(cyc);
      runs_exp++;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accum = 1'b0;
`endif
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", busy, '0);
  endtask

  // Monitor: every done pulse pops one expected result and latency.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: done=1 with no run pending (cycle %0d)", cyc);
      end else begin
        checkOutput("result", result, exp_q.pop_front());
        checkOutput("latency", RW'(cyc - start_q.pop_front() + 1), RW'(lat_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, '0);
    checkOutput("rst_done", done, '0);
    checkOutput("rst_arr_en", arr_en, '0);
    checkOutput("rst_arr_rst", arr_rst, RW'(1));
    checkOutput("rst_arr_left", arr_left, '0);
    checkOutput("rst_arr_top", arr_top, '0);
    checkOutput("rst_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // A = B = M, plus the skew snapshot at FEED t=2
    loadMatrix(1'b0, M);
    loadMatrix(1'b1, M);
    applyStimulus(1'b0, 1'b1, C1);
    repeat (3) @(negedge clk);
    checkOutput("skew_left_t2", arr_left, RW'(24'h070503));
    checkOutput("skew_top_t2", arr_top, RW'(24'h030507));
    checkOutput("feed_arr_en", arr_en, RW'(1));
    waitIdle();
    checkOutput("idle_left_zero", arr_left, '0);
    checkOutput("idle_arr_en", arr_en, '0);

    // Write to A[0][0] and a second start while busy must both be ignored
    applyStimulus(1'b0, 1'b1, C1);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = 8'd99;
    start   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("no_queued_start", busy, '0);
    applyStimulus(1'b0, 1'b1, C1);
    waitIdle();

    // Identity A with A[2][2] written in the same cycle as start
    loadMatrix(1'b0, IDP);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_row  = 2'd2;
    wr_col  = 2'd2;
    wr_data = 8'd1;
    applyStimulus(1'b0, 1'b1, M);
    waitIdle();

    // Full-scale operands
    loadMatrix(1'b0, FF);
    loadMatrix(1'b1, FF);
    applyStimulus(1'b0, 1'b1, CFF);
    waitIdle();

    // Reset during DRAIN aborts the run and clears the buffers
    loadMatrix(1'b0, A2);
    loadMatrix(1'b1, M);
    applyStimulus(1'b0, 1'b0, ZZ);
    repeat (6) @(negedge clk);
    checkOutput("drain_busy", busy, RW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, '0);
    checkOutput("abort_done", done, '0);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_arr_en", arr_en, '0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort_stays_idle", busy, '0);
    applyStimulus(1'b0, 1'b1, ZZ);
    waitIdle();
    loadMatrix(1'b0, A2);
    loadMatrix(1'b1, M);
    applyStimulus(1'b0, 1'b1, C2);
    waitIdle();

`ifdef SYSTOLIC_CTRL_ACCUM_EN
    // Second run with accum=1 adds onto the first run's sums
    loadMatrix(1'b0, M);
    loadMatrix(1'b1, M);
    applyStimulus(1'b0, 1'b1, C1);
    waitIdle();
    applyStimulus(1'b1, 1'b1, C1X2);
    waitIdle();
`endif

    repeat (4) @(negedge clk);
    checkOutput("pending_runs", RW'(exp_q.size()), '0);
    checkOutput("done_count", RW'(done_cnt), RW'(runs_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
